// File: rtl/btn_array_cntr.sv
// -----------------------------------------------------------------------------
// btn_array_cntr
//   Debounced push-button array.
//   Each channel synchronises its raw input, debounces it on a shared slow
//   sample tick, and reports:
//     * the debounced pressed level,
//     * one-clk press and release pulses,
//     * a one-clk long-press pulse after LONG_TICKS ticks of continuous hold,
//     * a one-clk auto-repeat pulse every RPT_TICKS ticks after that
//       (when repeat is enabled for the channel).
//
//   Parameters
//     N_BTN      number of channels (1..16)
//     TICK_DIV   sample tick period in clk cycles (2..2^20)
//     DEB_TICKS  consecutive differing samples to accept a level change (1..255)
//     LONG_TICKS hold ticks before the long-press pulse (DEB_TICKS+1..65535)
//     RPT_TICKS  auto-repeat period in ticks (1..65535)
//     ACTIVE_LOW 1 = raw inputs are inverted before synchronisation
//
//   Ports
//     clk         system clock, posedge
//     reset_p     asynchronous active-high reset
//     btn         raw asynchronous button inputs
//     rpt_en      per-channel auto-repeat enable
//     btn_level   debounced pressed state
//     btn_p_edge  one-clk pulse, first clk of btn_level = 1
//     btn_n_edge  one-clk pulse, first clk of btn_level = 0
//     btn_long    one-clk long-press pulse
//     btn_rpt     one-clk auto-repeat pulse
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// btn_chan
//   One button channel: 2-flop synchroniser, tick-driven debouncer,
//   edge detector and IDLE/PRESSED/HELD press-duration FSM.
//
//   Ports
//     clk, reset_p  clock / async active-high reset
//     tick_i        shared one-clk sample tick
//     raw_i         raw (already polarity-corrected) input
//     rpt_en_i      auto-repeat enable
//     level_o       debounced level
//     p_edge_o      press pulse
//     n_edge_o      release pulse
//     long_o        long-press pulse
//     rpt_o         auto-repeat pulse
// -----------------------------------------------------------------------------
module btn_chan #(
  parameter int DEB_TICKS  = 4,
  parameter int LONG_TICKS = 1000,
  parameter int RPT_TICKS  = 200
) (
  input  logic clk,
  input  logic reset_p,
  input  logic tick_i,
  input  logic raw_i,
  input  logic rpt_en_i,
  output logic level_o,
  output logic p_edge_o,
  output logic n_edge_o,
  output logic long_o,
  output logic rpt_o
);

  localparam int HMAX = (LONG_TICKS > RPT_TICKS) ? LONG_TICKS : RPT_TICKS;
  localparam int HW   = $clog2(HMAX) + 1;
  // debounce count only ranges 0..DEB_TICKS-1 before the level flips
  localparam int DW   = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(RPT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_e;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          lvl_q, lvl_d;
  logic          prev_q;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;
  logic          rpt_q, rpt_d;

  logic rise, fall;

  // ---------------------------------------------------------------------------
  // Debouncer: counts consecutive ticks where the synchronised input differs
  // from the accepted level; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    lvl_d = lvl_q;
    deb_d = deb_q;
    if (tick_i) begin
      if (sync2_q != lvl_q) begin
        if (deb_q == DEB_LAST) begin
          lvl_d = ~lvl_q;
          deb_d = '0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end else begin
        deb_d = '0;
      end
    end
  end

  // The FSM follows the level change at the same edge the level register
  // takes it, so a release landing on a long/repeat threshold tick is seen
  // in the same evaluation and suppresses that pulse.
  assign rise = ~lvl_q &  lvl_d;
  assign fall =  lvl_q & ~lvl_d;

  // ---------------------------------------------------------------------------
  // Press-duration FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    if (fall) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
            hold_d  = '0;
          end
        end
        PRESSED: begin
          if (tick_i) begin
            if (hold_q == LONG_LAST) begin
              state_d = HELD;
              hold_d  = '0;
              long_d  = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        HELD: begin
          // repeat disabled parks the counter so re-enabling starts a
          // fresh full period
          if (!rpt_en_i) begin
            hold_d = '0;
          end else if (tick_i) begin
            if (hold_q == RPT_LAST) begin
              hold_d = '0;
              rpt_d  = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      hold_q  <= '0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      state_q <= state_d;
      hold_q  <= hold_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o  = lvl_q;
  assign p_edge_o =  lvl_q & ~prev_q;
  assign n_edge_o = ~lvl_q &  prev_q;
  assign long_o   = long_q;
  assign rpt_o    = rpt_q;

endmodule

module btn_array_cntr #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 100000,
  parameter int DEB_TICKS  = 4,
  parameter int LONG_TICKS = 1000,
  parameter int RPT_TICKS  = 200,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_BTN-1:0] rpt_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_p_edge,
  output logic [N_BTN-1:0] btn_n_edge,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_rpt
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [N_BTN-1:0] raw;

  // ---------------------------------------------------------------------------
  // Shared sample tick: one clk high every TICK_DIV clks
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) tick_cnt_q <= '0;
    else         tick_cnt_q <= tick_cnt_d;
  end

  assign raw = (ACTIVE_LOW != 0) ? ~btn : btn;

  // ---------------------------------------------------------------------------
  // Per-channel instances
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_chan #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .RPT_TICKS  (RPT_TICKS)
    ) u_chan (
      .clk      (clk),
      .reset_p  (reset_p),
      .tick_i   (tick),
      .raw_i    (raw[g]),
      .rpt_en_i (rpt_en[g]),
      .level_o  (btn_level[g]),
      .p_edge_o (btn_p_edge[g]),
      .n_edge_o (btn_n_edge[g]),
      .long_o   (btn_long[g]),
      .rpt_o    (btn_rpt[g])
    );
  end

endmodule

// File: doc/btn_array_cntr.md
BTN_ARRAY_CNTR -- requirements
Module: btn_array_cntr

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, giving the number of independent button channels (1..16).
REQ-002 The block SHALL have parameter TICK_DIV, default 100000, giving the sample-tick period in clk cycles (1 ms at 100 MHz); legal range 2..2^20.
REQ-003 The block SHALL have parameter DEB_TICKS, default 4, giving the number of consecutive differing samples needed to accept a level change; legal range 1..255.
REQ-004 The block SHALL have parameter LONG_TICKS, default 1000, giving the hold time in ticks before the long-press pulse; legal range DEB_TICKS+1..65535.
REQ-005 The block SHALL have parameter RPT_TICKS, default 200, giving the auto-repeat period in ticks after a long press; legal range 1..65535.
REQ-006 The block SHALL have parameter ACTIVE_LOW, default 0; when set to 1, raw inputs are inverted before synchronisation.
REQ-007 The block SHALL have port clk, input, 1 bit: system clock; all logic on posedge.
REQ-008 The block SHALL have port reset_p, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port btn, input, N_BTN bits: raw asynchronous button inputs.
REQ-010 The block SHALL have port rpt_en, input, N_BTN bits: per-channel auto-repeat enable.
REQ-011 The block SHALL have port btn_level, output, N_BTN bits: debounced pressed state.
REQ-012 The block SHALL have ports btn_p_edge and btn_n_edge, outputs, N_BTN bits each: one-clk press and release pulses.
REQ-013 The block SHALL have port btn_long, output, N_BTN bits: one-clk long-press pulse.
REQ-014 The block SHALL have port btn_rpt, output, N_BTN bits: one-clk auto-repeat pulse.

Function
REQ-015 The block SHALL use a single shared tick counter that counts 0..TICK_DIV-1, wraps to 0, and asserts tick for one clk when count == TICK_DIV-1.
REQ-016 Each channel SHALL pass its (optionally inverted) input through a 2-flop synchroniser before any other use.
REQ-017 The debounce counter SHALL be updated only on tick: +1 if sync != btn_level, cleared if sync == btn_level.
REQ-018 When a tick occurs with sync != btn_level and the debounce count equals DEB_TICKS-1, btn_level SHALL toggle at that clk edge and the debounce count SHALL clear.
REQ-019 btn_p_edge (btn_n_edge) SHALL be high for exactly the first clk in which btn_level is 1 (0), implemented by registering the previous level.
REQ-020 Each channel SHALL implement an FSM with states IDLE, PRESSED and HELD.
REQ-021 FSM transitions: IDLE->PRESSED on level rise, hold count cleared; PRESSED->HELD on the tick at which the hold count reaches LONG_TICKS; any state->IDLE on level fall.
REQ-022 The hold counter SHALL increment by 1 per tick while in PRESSED or HELD, with a width of clog2 of the larger of LONG_TICKS and RPT_TICKS, plus 1.
REQ-023 btn_long SHALL pulse for one clk on the PRESSED->HELD transition.
REQ-024 On entering HELD the hold counter SHALL clear; then, while in HELD with rpt_en[i]=1, btn_rpt SHALL pulse for one clk on every tick where the count reaches RPT_TICKS, and the count SHALL clear to 0 on that tick.
REQ-025 While rpt_en[i]=0 in HELD, the hold counter SHALL hold at 0 and btn_rpt SHALL stay low.
REQ-026 If a level fall and the long/repeat threshold fall in the same clk, the release SHALL win: go to IDLE, btn_n_edge fires, and btn_long/btn_rpt do not fire.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same clk.
REQ-028 Input glitches shorter than DEB_TICKS consecutive ticks SHALL produce no output activity.

Reset
REQ-029 While reset_p=1, all outputs SHALL be 0, all FSMs SHALL be IDLE, and all counters and synchroniser flops SHALL be 0.
REQ-030 Reset asserted mid-press SHALL abort without any pulse; after release of reset, an input still held SHALL be re-debounced from zero and then produce a normal btn_p_edge.

Verification (N_BTN=2, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8, RPT_TICKS=2, ACTIVE_LOW=0)
REQ-031 Press btn[0] and hold -> btn_level[0] rises on the 3rd tick after the synchroniser output goes high; btn_p_edge[0] is high for exactly 1 clk.
REQ-032 Pulse btn[1] high for 2 ticks, then low -> btn_level, edges, long and rpt all stay 0.
REQ-033 Hold btn[0] with rpt_en=1 for 20 ticks after the level rise -> btn_long at tick 8, btn_rpt at ticks 10, 12, 14, 16, 18, 20; on release, btn_n_edge fires once.
REQ-034 Hold with rpt_en=0 -> btn_long fires once; btn_rpt never fires.
REQ-035 Press both channels in the same clk -> both btn_p_edge bits assert in the same clk.
REQ-036 Assert reset_p while in HELD, then deassert with the button still held -> all outputs go 0 immediately; a new btn_p_edge fires after 3 ticks and no btn_long fires before 8 more ticks.
